// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- eight-bit clocked arithmetic/logic unit with an internal accumulator.
//
// Each rising edge of clk, one of sixteen operations selected by opcode is
// applied to A, B and the current accumulator, and the 8-bit result is written
// back into the accumulator. The accumulator is the only output, so there is no
// combinational path from any input to ALU_Out.
//
// Ports:
//   clk      in   1  rising-edge clock for all state
//   reset    in   1  synchronous, active-high; clears the accumulator
//   A        in   8  operand A, unsigned
//   B        in   8  operand B, unsigned
//   opcode   in   4  operation select
//   ALU_Out  out  8  accumulator contents
//
// Opcode map (all arithmetic unsigned, modulo 256):
//   0000 A+B        0001 A-B        0010 A*B        0011 A/B (B=0 -> FF)
//   0100 A+acc      0101 A*acc      0110 acc+A*B    0111 rotate A left
//   1000 rotate A right             1001 A&B        1010 A|B
//   1011 A^B        1100 ~(A&B)     1101 A==B ? FF : 00
//   1110 nibble swap of A           1111 hold
// -----------------------------------------------------------------------------
module alu (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [3:0] opcode,
   output logic [7:0] ALU_Out
);

   // Opcode encodings
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_MUL   = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_ADDA  = 4'b0100;
   localparam logic [3:0] OP_MULA  = 4'b0101;
   localparam logic [3:0] OP_MAC   = 4'b0110;
   localparam logic [3:0] OP_ROL   = 4'b0111;
   localparam logic [3:0] OP_ROR   = 4'b1000;
   localparam logic [3:0] OP_AND   = 4'b1001;
   localparam logic [3:0] OP_OR    = 4'b1010;
   localparam logic [3:0] OP_XOR   = 4'b1011;
   localparam logic [3:0] OP_NAND  = 4'b1100;
   localparam logic [3:0] OP_EQ    = 4'b1101;
   localparam logic [3:0] OP_SWAP  = 4'b1110;
   localparam logic [3:0] OP_HOLD  = 4'b1111;

   logic [7:0] r_acc;
   logic [7:0] w_acc_next;

   // ------------------------------------------------------------------------
   // Multipliers: only the low 8 bits of each product are ever used, so the
   // products are formed at 8 bits directly.
   // ------------------------------------------------------------------------
   logic [7:0] w_mul_ab;
   logic [7:0] w_mul_aacc;

   assign w_mul_ab   = A * B;
   assign w_mul_aacc = A * r_acc;

   // ------------------------------------------------------------------------
   // Restoring divider, unrolled into eight combinational stages. Stage gi
   // brings down dividend bit (7-gi), tries to subtract B from the partial
   // remainder and keeps the difference when it does not go negative.
   // The partial remainder is always < B, so it fits in 8 bits.
   // ------------------------------------------------------------------------
   logic [7:0] w_rem [0:8];
   logic [7:0] w_quot;
   logic [7:0] w_div;

   assign w_rem[0] = 8'h00;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_div_stage
         logic [8:0] w_trial;
         logic [8:0] w_diff;

         assign w_trial         = {w_rem[gi], A[7-gi]};
         assign w_diff          = w_trial - {1'b0, B};
         assign w_quot[7-gi]    = ~w_diff[8];
         assign w_rem[gi+1]     = w_diff[8] ? w_trial[7:0] : w_diff[7:0];
      end
   endgenerate

   // Division by zero is defined to give all ones.
   assign w_div = (B == 8'h00) ? 8'hFF : w_quot;

   // ------------------------------------------------------------------------
   // Bit-permutation ops built per bit.
   // ------------------------------------------------------------------------
   logic [7:0] w_rol;
   logic [7:0] w_ror;
   logic [7:0] w_swap;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_perm
         assign w_rol[gi]  = A[(gi + 7) % 8];
         assign w_ror[gi]  = A[(gi + 1) % 8];
         assign w_swap[gi] = A[(gi + 4) % 8];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-accumulator select. Unmatched opcodes (only possible in simulation
   // with X/Z on opcode) fall through to the default and hold the value.
   // ------------------------------------------------------------------------
   always_comb begin
      w_acc_next = r_acc;
      case (opcode)
         OP_ADD:  w_acc_next = A + B;
         OP_SUB:  w_acc_next = A - B;
         OP_MUL:  w_acc_next = w_mul_ab;
         OP_DIV:  w_acc_next = w_div;
         OP_ADDA: w_acc_next = A + r_acc;
         OP_MULA: w_acc_next = w_mul_aacc;
         OP_MAC:  w_acc_next = r_acc + w_mul_ab;
         OP_ROL:  w_acc_next = w_rol;
         OP_ROR:  w_acc_next = w_ror;
         OP_AND:  w_acc_next = A & B;
         OP_OR:   w_acc_next = A | B;
         OP_XOR:  w_acc_next = A ^ B;
         OP_NAND: w_acc_next = ~(A & B);
         OP_EQ:   w_acc_next = (A == B) ? 8'hFF : 8'h00;
         OP_SWAP: w_acc_next = w_swap;
         OP_HOLD: w_acc_next = r_acc;
         default: w_acc_next = r_acc;
      endcase
   end

   // Reset takes priority over every opcode.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= 8'h00;
      end else begin
         r_acc <= w_acc_next;
      end
   end

   assign ALU_Out = r_acc;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- directed-vector bench for alu with a scoreboard queue.
// The driver applies one vector per clock (on the falling edge) and pushes the
// hand-computed accumulator value expected after the next rising edge; the
// monitor pops one entry after every rising edge and compares it with ALU_Out.
// -----------------------------------------------------------------------------
module tb_alu;

   logic       clk;
   logic       reset;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] opcode;
   logic [7:0] ALU_Out;

   typedef struct {
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   alu dut (
      .clk     (clk),
      .reset   (reset),
      .A       (A),
      .B       (B),
      .opcode  (opcode),
      .ALU_Out (ALU_Out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every rising edge with an outstanding expectation produces one
   // accumulator value to check.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (ALU_Out === e.exp) begin
            n_pass++;
            $display("ok   %-14s A=%02h B=%02h ALU_Out=%02h", e.name, A, B, ALU_Out);
         end else begin
            $display("FAIL %-14s got=%02h expected=%02h", e.name, ALU_Out, e.exp);
         end
      end
   end

   task automatic apply(input logic rst, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [7:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      reset  = rst;
      A      = a;
      B      = b;
      opcode = op;
      e.exp  = exp;
      e.name = name;
      exp_q.push_back(e);
   endtask

   initial begin
      int budget;
      reset  = 1'b0;
      A      = 8'h00;
      B      = 8'h00;
      opcode = 4'b1111;

      // Reset then accumulate
      apply(1, 8'h01, 8'h01, 4'b0100, 8'h00, "reset");
      apply(0, 8'h01, 8'h01, 4'b0100, 8'h01, "acc1");
      apply(0, 8'h01, 8'h01, 4'b0100, 8'h02, "acc2");
      apply(0, 8'h01, 8'h01, 4'b0100, 8'h03, "acc3");

      // Reset held over two edges regardless of opcode
      apply(1, 8'h01, 8'h01, 4'b0000, 8'h00, "reset_hold1");
      apply(1, 8'h33, 8'h01, 4'b0100, 8'h00, "reset_hold2");

      // Wrap-around
      apply(0, 8'hFF, 8'h00, 4'b0100, 8'hFF, "wrap_acc1");
      apply(0, 8'hFF, 8'h00, 4'b0100, 8'hFE, "wrap_acc2");
      apply(0, 8'h01, 8'h02, 4'b0001, 8'hFF, "sub_wrap");
      apply(0, 8'hC8, 8'h64, 4'b0000, 8'h2C, "add_wrap");

      // Multiply / divide
      apply(0, 8'h10, 8'h11, 4'b0010, 8'h10, "mul_trunc");
      apply(0, 8'h07, 8'h02, 4'b0011, 8'h03, "div");
      apply(0, 8'h07, 8'h00, 4'b0011, 8'hFF, "div_by_zero");
      apply(0, 8'hFF, 8'h10, 4'b0011, 8'h0F, "div_ff_10");
      apply(0, 8'h05, 8'h07, 4'b0011, 8'h00, "div_small");
      apply(0, 8'hFF, 8'h01, 4'b0011, 8'hFF, "div_by_one");

      // Logic / bit ops
      apply(0, 8'hA5, 8'h0F, 4'b1001, 8'h05, "and");
      apply(0, 8'hA5, 8'h0F, 4'b1010, 8'hAF, "or");
      apply(0, 8'hA5, 8'h0F, 4'b1011, 8'hAA, "xor");
      apply(0, 8'hA5, 8'h0F, 4'b1100, 8'hFA, "nand");
      apply(0, 8'hA5, 8'h0F, 4'b0111, 8'h4B, "rol");
      apply(0, 8'hA5, 8'h0F, 4'b1000, 8'hD2, "ror");
      apply(0, 8'hA5, 8'h0F, 4'b1110, 8'h5A, "swap");
      apply(0, 8'h3C, 8'h3C, 4'b1101, 8'hFF, "eq_true");
      apply(0, 8'h3C, 8'h3D, 4'b1101, 8'h00, "eq_false");

      // MAC and hold
      apply(1, 8'h02, 8'h03, 4'b0110, 8'h00, "reset_mac");
      apply(0, 8'h02, 8'h03, 4'b0110, 8'h06, "mac1");
      apply(0, 8'h02, 8'h03, 4'b0110, 8'h0C, "mac2");
      apply(0, 8'h55, 8'hAA, 4'b1111, 8'h0C, "hold1");
      apply(0, 8'hFF, 8'h01, 4'b1111, 8'h0C, "hold2");
      apply(0, 8'h00, 8'h00, 4'b1111, 8'h0C, "hold3");
      apply(0, 8'h03, 8'h00, 4'b0101, 8'h24, "mul_acc");

      // Reset mid-operation
      apply(1, 8'h01, 8'h00, 4'b0100, 8'h00, "reset_mid0");
      apply(0, 8'h01, 8'h00, 4'b0100, 8'h01, "count1");
      apply(0, 8'h01, 8'h00, 4'b0100, 8'h02, "count2");
      apply(0, 8'h01, 8'h00, 4'b0100, 8'h03, "count3");
      apply(0, 8'h01, 8'h00, 4'b0100, 8'h04, "count4");
      apply(0, 8'h01, 8'h00, 4'b0100, 8'h05, "count5");
      apply(1, 8'h01, 8'h00, 4'b0100, 8'h00, "reset_mid");
      apply(0, 8'h01, 8'h00, 4'b0100, 8'h01, "after_reset");

      // Drain the scoreboard with a bounded wait.
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() > 0) begin
         $display("FAIL drain_timeout got=%0d pending expected=0 pending", exp_q.size());
         n_checks += exp_q.size();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
